// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer memory arbiter.
//   FB_ADDR_W / FB_DATA_W / FB_WBEN_W : framebuffer word address, data and byte-enable widths
//   OP_WRITE / OP_READ                 : encoding of the per-request op bit
//   arb_state_e                        : arbiter FSM state encoding
//   idx_width()                        : width of a requester index for a given port count
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 32;
    localparam int FB_WBEN_W = 4;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // A single-port configuration still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin first-one search.
//   req       in  NREQ   request vector
//   ptr       in  IDX_W  highest-priority port this cycle
//   grant     out NREQ   one-hot grant (zero when no request)
//   grant_idx out IDX_W  encoded grant index (zero when no request)
//   any       out 1      at least one request present
module rr_picker
    import fb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]             req,
    input  logic [idx_width(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]             grant,
    output logic [idx_width(NREQ)-1:0]  grant_idx,
    output logic                        any
);

    localparam int IDX_W = idx_width(NREQ);

    logic [IDX_W-1:0] idx;

    // Walk ports ptr, ptr+1, ... wrapping at NREQ; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: round-robin arbiter sharing one synchronous-SRAM framebuffer port
// between NREQ drawing engines, with bounded bursts and read-return steering.
//   clk, rst                  clock, asynchronous active-high reset
//   req_data/addr/wben/op     per-port request payload, port i in slice i
//   req_rts / req_rtr         per-port request valid / accepted this cycle
//   rd_data / rd_valid        shared read return bus / one-hot return strobe
//   mem_stall                 memory port borrowed by scanout, no transfers
//   mem_en/we/addr/wdata/wben registered SRAM command
//   mem_rdata                 SRAM read data, one cycle after a read command
//
// Handshake: a transfer on port i happens on the rising edge where both
// req_rts[i] and req_rtr[i] are high. req_rts may rise at any time and is
// expected to hold until accepted; req_rtr is combinational from req_rts and
// is never high on more than one port.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FB_DATA_W*NREQ-1:0] req_data,
    input  logic [FB_ADDR_W*NREQ-1:0] req_addr,
    input  logic [FB_WBEN_W*NREQ-1:0] req_wben,
    input  logic [NREQ-1:0]           req_op,
    input  logic [NREQ-1:0]           req_rts,
    output logic [NREQ-1:0]           req_rtr,
    output logic [FB_DATA_W-1:0]      rd_data,
    output logic [NREQ-1:0]           rd_valid,
    input  logic                      mem_stall,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [FB_ADDR_W-1:0]      mem_addr,
    output logic [FB_DATA_W-1:0]      mem_wdata,
    output logic [FB_WBEN_W-1:0]      mem_wben,
    input  logic [FB_DATA_W-1:0]      mem_rdata
);

    localparam int         IDX_W       = idx_width(NREQ);
    localparam logic [8:0] MAX_BURST_C = 9'(MAX_BURST);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         burst_cnt_q, burst_cnt_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [FB_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [FB_DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [FB_WBEN_W-1:0] mem_wben_q, mem_wben_d;
    // Read tag follows the command stage, then the SRAM data stage.
    logic [NREQ-1:0]    rd_tag_a_q, rd_tag_a_d;
    logic [NREQ-1:0]    rd_tag_m_q, rd_tag_m_d;
    logic [NREQ-1:0]    rd_valid_q, rd_valid_d;
    logic [FB_DATA_W-1:0] rd_data_q, rd_data_d;

    logic [FB_DATA_W-1:0] data_arr [NREQ];
    logic [FB_ADDR_W-1:0] addr_arr [NREQ];
    logic [FB_WBEN_W-1:0] wben_arr [NREQ];

    logic               holding;
    logic [IDX_W-1:0]   owner_inc, pick_inc, scan_ptr, pick_idx, sel_idx;
    logic [NREQ-1:0]    pick_grant;
    logic               pick_any, xfer, sel_op;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = req_data[i*FB_DATA_W +: FB_DATA_W];
            addr_arr[i] = req_addr[i*FB_ADDR_W +: FB_ADDR_W];
            wben_arr[i] = req_wben[i*FB_WBEN_W +: FB_WBEN_W];
        end
    end

    // Burst owner keeps the port only while it keeps requesting. Once it drops
    // rts the scan restarts from owner+1 in the same cycle, so a waiting port
    // is handed the slot with no idle cycle.
    assign holding   = (state_q == ARB_BURST) && req_rts[owner_q];
    assign owner_inc = (owner_q  == IDX_W'(NREQ-1)) ? '0 : owner_q  + IDX_W'(1);
    assign pick_inc  = (pick_idx == IDX_W'(NREQ-1)) ? '0 : pick_idx + IDX_W'(1);
    assign scan_ptr  = (state_q == ARB_BURST) ? owner_inc : rr_ptr_q;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req       (req_rts),
        .ptr       (scan_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    always_comb begin
        req_rtr = '0;
        if (!rst && !mem_stall) begin
            if (holding) begin
                req_rtr[owner_q] = 1'b1;
            end else if (pick_any) begin
                req_rtr = pick_grant;
            end
        end
    end

    assign xfer    = |req_rtr;
    assign sel_idx = holding ? owner_q : pick_idx;
    assign sel_op  = req_op[sel_idx];

    // Arbitration state. burst_cnt counts transfers already made in this
    // burst including the current one, so the burst ends on the transfer
    // that brings it to MAX_BURST.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        if (!mem_stall) begin
            if (state_q == ARB_BURST && !holding) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = owner_inc;
            end
            if (xfer) begin
                if (holding) begin
                    burst_cnt_d = burst_cnt_q + 8'd1;
                    if ({1'b0, burst_cnt_q} + 9'd1 >= MAX_BURST_C) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end else begin
                    owner_d     = pick_idx;
                    burst_cnt_d = 8'd1;
                    if (MAX_BURST_C == 9'd1) begin
                        state_d  = ARB_IDLE;
                        rr_ptr_d = pick_inc;
                    end else begin
                        state_d = ARB_BURST;
                    end
                end
            end
        end
    end

    // Registered memory command and read-return pipeline.
    always_comb begin
        mem_en_d    = xfer;
        mem_we_d    = xfer && (sel_op == OP_WRITE);
        mem_addr_d  = xfer ? addr_arr[sel_idx] : mem_addr_q;
        mem_wdata_d = xfer ? data_arr[sel_idx] : mem_wdata_q;
        mem_wben_d  = mem_wben_q;
        if (xfer) begin
            mem_wben_d = (sel_op == OP_WRITE) ? wben_arr[sel_idx] : '0;
        end
        rd_tag_a_d  = (xfer && sel_op == OP_READ) ? req_rtr : '0;
        rd_tag_m_d  = rd_tag_a_q;
        rd_valid_d  = rd_tag_m_q;
        rd_data_d   = (|rd_tag_m_q) ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wben_q  <= '0;
            rd_tag_a_q  <= '0;
            rd_tag_m_q  <= '0;
            rd_valid_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wben_q  <= mem_wben_d;
            rd_tag_a_q  <= rd_tag_a_d;
            rd_tag_m_q  <= rd_tag_m_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wben  = mem_wben_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule
